// File: rtl/button_blip_pkg.sv
// Shared types and default timing for the push-button blip conditioner.
// Default cycle counts assume the 100 MHz system clock.
package button_blip_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    REPEAT,
    RELEASE_WAIT
  } btn_state_e;

  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;   // 10 ms
  localparam int DEF_REPEAT_DELAY    = 50_000_000;  // 500 ms
  localparam int DEF_REPEAT_PERIOD   = 10_000_000;  // 100 ms
  localparam int DEF_REPEAT_EN       = 1;
  localparam int DEF_CNT_W           = 32;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // A press counts as held from acceptance until the release is debounced.
  function automatic logic state_is_held(input btn_state_e s);
    return (s == HELD) || (s == REPEAT) || (s == RELEASE_WAIT);
  endfunction

endpackage

// File: rtl/button_blip_btn_channel.sv
// One button: 2-FF synchroniser, debounce/auto-repeat FSM with a single timer,
// registered raw blip and combinational held level.
module btn_channel
  import button_blip_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int REPEAT_EN       = DEF_REPEAT_EN,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic blip_o,
  output logic held_o
);

  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST    = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST    = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] TIMER_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] TIMER_MAX  = '1;
  localparam logic             REPEAT_ON  = (REPEAT_EN != 0);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             blip_q, blip_d;

  always_comb begin
    sync1_d = btn_i;
    sync2_d = sync1_q;
    state_d = state_q;
    timer_d = timer_q;
    blip_d  = 1'b0;

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (sync2_q) begin
          state_d = PRESS_WAIT;
          timer_d = TIMER_ONE;
        end
      end

      PRESS_WAIT: begin
        if (!sync2_q) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (timer_q == DB_LAST) begin
          state_d = HELD;
          blip_d  = 1'b1;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end

      HELD: begin
        if (!sync2_q) begin
          state_d = RELEASE_WAIT;
          timer_d = TIMER_ONE;
        end else if (REPEAT_ON && (timer_q == RD_LAST)) begin
          state_d = REPEAT;
          blip_d  = 1'b1;
          timer_d = '0;
        end else if (timer_q != TIMER_MAX) begin
          // Saturate so a long hold with repeat disabled never wraps.
          timer_d = timer_q + TIMER_ONE;
        end
      end

      REPEAT: begin
        if (!sync2_q) begin
          state_d = RELEASE_WAIT;
          timer_d = TIMER_ONE;
        end else if (timer_q == RP_LAST) begin
          blip_d  = 1'b1;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end

      RELEASE_WAIT: begin
        // A release glitch drops back to HELD, so the repeat delay restarts.
        if (sync2_q) begin
          state_d = HELD;
          timer_d = '0;
        end else if (timer_q == DB_LAST) begin
          state_d = IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end

      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= IDLE;
      timer_q <= '0;
      blip_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      timer_q <= timer_d;
      blip_q  <= blip_d;
    end
  end

  assign blip_o = blip_q;
  assign held_o = state_is_held(state_q);

endmodule

// File: rtl/button_blip.sv
// Up/down button conditioner: two debounced channels followed by a registered
// conflict-cancel and enable-mask stage producing one-cycle user blips.
module button_blip
  import button_blip_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int REPEAT_EN       = DEF_REPEAT_EN,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic Clk100M,
  input  logic reset,
  input  logic btnUp,
  input  logic btnDown,
  input  logic enable,
  output logic userUp,
  output logic userDown,
  output logic upHeld,
  output logic downHeld
);

  if ((DEBOUNCE_CYCLES < 2) || (REPEAT_DELAY < 2) || (REPEAT_PERIOD < 2)) begin : g_bad_timing
    $error("button_blip: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 2");
  end

  if ((CNT_W < 63) &&
      (longint'(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) >= (longint'(1) << CNT_W)))
  begin : g_bad_width
    $error("button_blip: CNT_W too narrow for the timing parameters");
  end

  logic up_blip, up_held;
  logic down_blip, down_held;

  btn_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD),
    .REPEAT_EN      (REPEAT_EN),
    .CNT_W          (CNT_W)
  ) u_up (
    .clk   (Clk100M),
    .rst   (reset),
    .btn_i (btnUp),
    .blip_o(up_blip),
    .held_o(up_held)
  );

  btn_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD),
    .REPEAT_EN      (REPEAT_EN),
    .CNT_W          (CNT_W)
  ) u_down (
    .clk   (Clk100M),
    .rst   (reset),
    .btn_i (btnDown),
    .blip_o(down_blip),
    .held_o(down_held)
  );

  logic user_up_q,   user_up_d;
  logic user_down_q, user_down_d;
  logic up_held_q,   up_held_d;
  logic down_held_q, down_held_d;

  // Simultaneous up and down cancel to no change; masked blips are dropped.
  always_comb begin
    user_up_d   = up_blip   & ~down_blip & enable;
    user_down_d = down_blip & ~up_blip   & enable;
    up_held_d   = up_held;
    down_held_d = down_held;
  end

  always_ff @(posedge Clk100M) begin
    if (reset) begin
      user_up_q   <= 1'b0;
      user_down_q <= 1'b0;
      up_held_q   <= 1'b0;
      down_held_q <= 1'b0;
    end else begin
      user_up_q   <= user_up_d;
      user_down_q <= user_down_d;
      up_held_q   <= up_held_d;
      down_held_q <= down_held_d;
    end
  end

  assign userUp   = user_up_q;
  assign userDown = user_down_q;
  assign upHeld   = up_held_q;
  assign downHeld = down_held_q;

endmodule
